sevenseg_scan_decoder: RTL

Receive-side counterpart of the 4-digit seven-segment driver. The block watches the multiplexed anode strobes and segment cathodes and decodes each digit back to BCD. It assembles complete frames into a binary value for loop-back self-test and bench checking of display paths, such as the Fitbit step and mile displays. It sits on the same 100 MHz clock as the driver and taps the driver's outputs directly.

---
 rtl/sevenseg_scan_decoder.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_decoder.sv
// ----------------------------------------------------------------------------
// sevenseg_scan_decoder
//   Watches the multiplexed anode strobes and active-low segment cathodes of a
//   4-digit seven-segment driver, decodes each digit back to BCD and publishes
//   complete frames as a binary value for loop-back self-test.
//
// Parameters
//   SETTLE_CYCLES  : cycles the strobe/segments must hold before sampling (1..255)
//   TIMEOUT_CYCLES : cycles without a capture before scanLost asserts
//
// Ports
//   CLK            : system clock, rising edge
//   RESET          : synchronous, active-high reset
//   anodeSelect0-3 : active-low digit enables (0 = ones ... 3 = thousands)
//   sevenSeg[6:0]  : active-low cathodes, bit0 = a ... bit6 = g
//   decodedValue   : last complete frame as binary (0..9999)
//   bcdDigits      : last complete frame as BCD {d3,d2,d1,d0}
//   blankMask      : bit i set when digit i was blank in the last frame
//   patternError   : last frame contained a non-digit pattern
//   frameValid     : one-cycle pulse when a new frame is published
//   scanLost       : no digit captured for TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module sevenseg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        anodeSelect0,
  input  logic        anodeSelect1,
  input  logic        anodeSelect2,
  input  logic        anodeSelect3,
  input  logic [6:0]  sevenSeg,
  output logic [13:0] decodedValue,
  output logic [15:0] bcdDigits,
  output logic [3:0]  blankMask,
  output logic        patternError,
  output logic        frameValid,
  output logic        scanLost
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]    ST_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    ST_MAX  = 8'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

  // Input stage and previous-cycle copy for change detection
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic [10:0]   r_prev;

  logic [7:0]    r_stable;
  logic          r_captured;
  logic [TW-1:0] r_to;
  logic          r_lost;

  // Frame under assembly
  logic [3:0]    r_slot [4];
  logic [3:0]    r_seen;
  logic [3:0]    r_blank;
  logic          r_err;

  // Published frame
  logic [13:0]   r_value;
  logic [15:0]   r_bcd;
  logic [3:0]    r_bmask;
  logic          r_perr;
  logic          r_fv;

  logic          w_same;
  logic          w_valid;
  logic [3:0]    w_sel;
  logic          w_capture;
  logic          w_timeout;
  logic          w_complete;
  logic [3:0]    w_digit;
  logic          w_is_blank;
  logic          w_is_bad;
  logic [3:0]    w_slot_n [4];
  logic [3:0]    w_seen_n;
  logic [3:0]    w_blank_n;
  logic          w_err_n;
  logic [13:0]   w_value;

  // --------------------------------------------------------------------------
  // Input registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_an   <= '0;
      r_seg  <= '0;
      r_prev <= '0;
    end else begin
      r_an   <= {anodeSelect3, anodeSelect2, anodeSelect1, anodeSelect0};
      r_seg  <= sevenSeg;
      r_prev <= {r_an, r_seg};
    end
  end

  // --------------------------------------------------------------------------
  // Strobe qualification and capture condition
  // --------------------------------------------------------------------------
  assign w_same = ({r_an, r_seg} == r_prev);
  assign w_sel  = ~r_an;

  always_comb begin
    w_valid = 1'b0;
    case (w_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_valid = 1'b1;
      default:                            w_valid = 1'b0;
    endcase
  end

  // w_same is also required so a new strobe arriving right as the counter
  // reaches its last value cannot be sampled after a single cycle.
  assign w_capture = w_valid && w_same && (r_stable == ST_LAST) && !r_captured;
  assign w_timeout = !w_capture && (r_to == TO_LAST);

  // --------------------------------------------------------------------------
  // Segment decode (active-low, g..a)
  // --------------------------------------------------------------------------
  always_comb begin
    w_digit    = 4'd0;
    w_is_blank = 1'b0;
    w_is_bad   = 1'b0;
    case (r_seg)
      7'b1000000:             w_digit = 4'd0;
      7'b1111001:             w_digit = 4'd1;
      7'b0100100:             w_digit = 4'd2;
      7'b0110000:             w_digit = 4'd3;
      7'b0011001:             w_digit = 4'd4;
      7'b0010010:             w_digit = 4'd5;
      7'b0000010:             w_digit = 4'd6;
      7'b1111000, 7'b1011000: w_digit = 4'd7;
      7'b0000000:             w_digit = 4'd8;
      7'b0010000, 7'b0011000: w_digit = 4'd9;
      7'b1111111:             w_is_blank = 1'b1;
      default:                w_is_bad   = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next frame contents including this edge's capture, so a completing
  // capture can be published on the same edge it lands.
  // --------------------------------------------------------------------------
  always_comb begin
    w_seen_n  = r_seen;
    w_blank_n = r_blank;
    w_err_n   = r_err;
    for (int unsigned i = 0; i < 4; i++) begin
      w_slot_n[i] = r_slot[i];
      if (w_capture && w_sel[i]) begin
        w_slot_n[i]  = w_digit;
        w_seen_n[i]  = 1'b1;
        w_blank_n[i] = w_is_blank;
      end
    end
    if (w_capture && w_is_bad) w_err_n = 1'b1;
  end

  assign w_complete = w_capture && (w_seen_n == 4'b1111);

  assign w_value = 14'(w_slot_n[3]) * 14'd1000
                 + 14'(w_slot_n[2]) * 14'd100
                 + 14'(w_slot_n[1]) * 14'd10
                 + 14'(w_slot_n[0]);

  // --------------------------------------------------------------------------
  // Stable counter and one-capture-per-dwell flag
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stable   <= '0;
      r_captured <= 1'b0;
    end else if (!w_same) begin
      r_stable   <= '0;
      r_captured <= 1'b0;
    end else if (!w_valid) begin
      r_stable   <= '0;
    end else begin
      if (r_stable != ST_MAX) r_stable <= r_stable + 8'd1;
      if (w_capture)          r_captured <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Capture timeout / scan-lost flag
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_to   <= '0;
      r_lost <= 1'b0;
    end else if (w_capture) begin
      r_to <= '0;
      if (w_complete) r_lost <= 1'b0;
    end else begin
      if (r_to != TO_MAX) r_to <= r_to + TW'(1);
      if (w_timeout)      r_lost <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame assembly
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 4; i++) r_slot[i] <= '0;
      r_seen  <= '0;
      r_blank <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) r_slot[i] <= w_slot_n[i];
      if (w_complete || w_timeout) begin
        r_seen  <= '0;
        r_blank <= '0;
        r_err   <= 1'b0;
      end else begin
        r_seen  <= w_seen_n;
        r_blank <= w_blank_n;
        r_err   <= w_err_n;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Published outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_value <= '0;
      r_bcd   <= '0;
      r_bmask <= '0;
      r_perr  <= 1'b0;
      r_fv    <= 1'b0;
    end else begin
      r_fv <= w_complete;
      if (w_complete) begin
        r_value <= w_value;
        r_bcd   <= {w_slot_n[3], w_slot_n[2], w_slot_n[1], w_slot_n[0]};
        r_bmask <= w_blank_n;
        r_perr  <= w_err_n;
      end
    end
  end

  assign decodedValue = r_value;
  assign bcdDigits    = r_bcd;
  assign blankMask    = r_bmask;
  assign patternError = r_perr;
  assign frameValid   = r_fv;
  assign scanLost     = r_lost;

endmodule
